// File: rtl/lifo_stack.sv
// Parametrised synchronous LIFO: array storage indexed by a stack pointer that doubles as the
// occupancy count, with a registered pop output, replace/bypass on push+pop, and sticky error flags.
module lifo_stack #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 10
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Clear,
  input  logic              Push,
  input  logic              Pop,
  input  logic [WIDTH-1:0]  DataIn,
  output logic [WIDTH-1:0]  DataOut,
  output logic              Valid,
  output logic [ADDR_W:0]   Count,
  output logic              Empty,
  output logic              Full,
  output logic              Overflow,
  output logic              Underflow
);

  localparam int              DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] SP_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] SP_FULL = {1'b1, {ADDR_W{1'b0}}};

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W:0]   sp_reg;
  logic [ADDR_W:0]   sp_next;
  logic [ADDR_W:0]   sp_dec;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic              wr_en;
  logic              rd_en;
  logic              bypass;
  logic              ovf_set;
  logic              unf_set;

  assign sp_dec  = sp_reg - SP_ONE;
  assign rd_addr = sp_dec[ADDR_W-1:0];
  assign Count   = sp_reg;
  assign Empty   = (sp_reg == '0);
  assign Full    = (sp_reg == SP_FULL);

  always_comb begin
    sp_next = sp_reg;
    wr_en   = 1'b0;
    wr_addr = sp_reg[ADDR_W-1:0];
    rd_en   = 1'b0;
    bypass  = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (Clear) begin
      sp_next = '0;
    end else begin
      case ({Push, Pop})
        2'b10: begin
          if (!Full) begin
            wr_en   = 1'b1;
            sp_next = sp_reg + SP_ONE;
          end else begin
            ovf_set = 1'b1;
          end
        end
        2'b01: begin
          if (!Empty) begin
            rd_en   = 1'b1;
            sp_next = sp_dec;
          end else begin
            unf_set = 1'b1;
          end
        end
        2'b11: begin
          // Replace the top in place; an empty stack forwards DataIn straight to the output.
          if (!Empty) begin
            rd_en   = 1'b1;
            wr_en   = 1'b1;
            wr_addr = rd_addr;
          end else begin
            bypass  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Storage carries no reset so it maps onto block RAM; writes are suppressed while in reset.
  always_ff @(posedge Clk) begin
    if (wr_en && Rst_n) begin
      mem[wr_addr] <= DataIn;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sp_reg    <= '0;
      DataOut   <= '0;
      Valid     <= 1'b0;
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
    end else begin
      sp_reg <= sp_next;
      Valid  <= rd_en | bypass;
      if (rd_en) begin
        DataOut <= mem[rd_addr];
      end else if (bypass) begin
        DataOut <= DataIn;
      end
      if (Clear) begin
        Overflow  <= 1'b0;
        Underflow <= 1'b0;
      end else begin
        if (ovf_set) Overflow  <= 1'b1;
        if (unf_set) Underflow <= 1'b1;
      end
    end
  end

endmodule

// File: doc/lifo_stack.md
# lifo_stack

Parametrised synchronous LIFO stack. It pairs an internal single-port-style memory array with a stack pointer, push/pop handshake, occupancy count, and sticky error flags. It is the clocked successor to the fixed 1024×8 asynchronous RAM in the stack datapath: width and depth become parameters, and push/pop sequencing moves into the block instead of being driven by external address and RWS/CS control.

## Interface
- WIDTH, 8: data word width in bits.
- ADDR_W, 10: address width; DEPTH = 2^ADDR_W entries.
- Clk  input  1  single clock; all state updates on the rising edge.
- Rst_n  input  1  asynchronous, active-low reset.
- Clear  input  1  synchronous flush; highest priority after reset.
- Push  input  1  write DataIn onto the stack this cycle.
- Pop  input  1  remove the top entry; it appears on DataOut next cycle.
- DataIn  input  WIDTH  push data.
- DataOut  output  WIDTH  registered popped word; holds its value until the next successful pop.
- Valid  output  1  one-cycle pulse: DataOut was updated by a pop this cycle.
- Count  output  ADDR_W+1  number of stored entries, 0..DEPTH.
- Empty  output  1  Count == 0.
- Full  output  1  Count == DEPTH.
- Overflow  output  1  sticky; set by a Push rejected while Full.
- Underflow  output  1  sticky; set by a Pop rejected while Empty.

## Operation
- Storage: DEPTH×WIDTH array with no reset. Stack pointer SP equals Count, and the top entry is mem[SP-1].
- Priority per edge: Rst_n low, then Clear, then the Push/Pop decode.
- Clear: SP←0, Overflow←0, Underflow←0, Valid←0, DataOut held, memory untouched.
- Push only, not Full: mem[SP]←DataIn, SP←SP+1.
- Push only, Full: no write, SP held, Overflow←1.
- Pop only, not Empty: DataOut←mem[SP-1], SP←SP-1, Valid←1.
- Pop only, Empty: SP held, DataOut held, Valid←0, Underflow←1.
- Push+Pop, not Empty (includes Full): replace top.
  - DataOut←old mem[SP-1] (read-before-write), then mem[SP-1]←DataIn.
  - SP held, Valid←1, no flag change.
- Push+Pop, Empty: bypass. DataOut←DataIn, Valid←1, SP held at 0, no memory write, no flag change.
- Neither asserted: SP held, Valid←0.
- Overflow and Underflow clear only on Rst_n or Clear.
- Empty and Full are decoded combinationally from the SP register. There is no separate state machine: SP plus the flags are the full state.

## Timing
- Reset values: Count=0, Empty=1, Full=0, DataOut=0, Valid=0, Overflow=0, Underflow=0.
- Reset asserts asynchronously at any time. A push or pop in the same cycle is discarded.
- Pop latency is 1 cycle. Pop sampled at edge N gives DataOut/Valid valid after edge N, for cycle N+1.
- A push is visible to a pop issued on the very next cycle; there is no read-after-write hazard.
- Count, Empty and Full reflect every operation one edge after it is sampled.
- Full throughput: one push or one pop or one replace per cycle, sustained indefinitely.
- SP arithmetic is ADDR_W+1 bits wide and never wraps. Guards stop increment past DEPTH and decrement below 0.
- Memory index is SP[ADDR_W-1:0] for writes and (SP-1)[ADDR_W-1:0] for reads.

## Test plan
- Reset: drive Rst_n low mid-cycle with Push=1 -> outputs take reset values immediately; after release, Count=0 and Empty=1.
- Ordering (ADDR_W=10, WIDTH=8):
  - Stimulus: push 0x11, 0x22, 0x33, then pop ×3 on back-to-back cycles.
  - Response: DataOut reads 0x33, 0x22, 0x11 with Valid=1 each cycle; Count goes 3→0; Empty=1 at the end.
- Full/overflow (ADDR_W=3):
  - Stimulus: push 8 words, then a 9th push of 0xFF.
  - Response: Full=1 and Count=8 after the 8th push; the 9th push sets Overflow=1 and leaves Count=8.
  - Popping all 8 returns the first 8 words, with no 0xFF.
- Underflow: pop while Empty -> Valid=0, DataOut unchanged, Underflow=1 and stays 1 until Clear; Clear -> Underflow=0.
- Simultaneous:
  - Stimulus: push 0xA5, then Push+Pop with DataIn=0x5A.
  - Response: DataOut=0xA5, Valid=1, Count stays 1; a following pop returns 0x5A.
  - On an empty stack, Push+Pop with DataIn=0x3C gives DataOut=0x3C, Valid=1, Count=0.
- Clear mid-operation: push 5 words, then Clear together with Push=1 -> Count=0, Empty=1, no write; a following pop sets Underflow.
